// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared definitions for the up/down counter family. Holds the
//            wrap/saturate mode encodings and the next-count step function so
//            single- and multi-channel counters compute identical results.
// Contents : MODE_WRAP, MODE_SAT   - bound behaviour encodings
//            c_FN_W                - data width of the shared step function
//            next_count()          - returns {event, next_q}
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Fixed working width of next_count(); callers zero-extend their count
    // into it and take back only their low WIDTH bits.
    localparam int c_FN_W = 32;

    // One counting step. The step is done in c_FN_W+1 bits so that carry out
    // of the top and borrow below zero are both visible, instead of relying
    // on natural overflow (which would be wrong for non-power-of-2 ranges).
    // Result bit c_FN_W is the wrap/saturation event; the rest is next_q.
    function automatic logic [c_FN_W:0] next_count(
        input logic [c_FN_W-1:0] q,
        input logic              up_dn,
        input logic [c_FN_W-1:0] max,
        input logic              sat
    );
        logic [c_FN_W:0]   w_sum;
        logic              w_evt;
        logic [c_FN_W-1:0] w_nq;
        if (up_dn) begin
            w_sum = {1'b0, q} + (c_FN_W+1)'(1);
            if (w_sum > {1'b0, max}) begin
                w_evt = 1'b1;
                w_nq  = sat ? q : '0;
            end else begin
                w_evt = 1'b0;
                w_nq  = w_sum[c_FN_W-1:0];
            end
        end else begin
            w_sum = {1'b0, q} - (c_FN_W+1)'(1);
            // Borrow out of the top bit means q was already zero.
            if (w_sum[c_FN_W]) begin
                w_evt = 1'b1;
                w_nq  = sat ? q : max;
            end else begin
                w_evt = 1'b0;
                w_nq  = w_sum[c_FN_W-1:0];
            end
        end
        return {w_evt, w_nq};
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Purpose  : Parametrised synchronous up/down counter, modulo MAX_COUNT+1,
//            with enable, synchronous clear, clamped parallel load and
//            selectable wrap or saturate behaviour at the bounds.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous reset, active low
//            en       - count enable for this cycle
//            up_dn    - direction, 1 = up, 0 = down
//            clr      - synchronous clear to 0 (highest priority)
//            load     - synchronous parallel load
//            load_val - value to load, clamped to MAX_COUNT
//            q        - current count (registered)
//            tc       - terminal count (combinational), cascade enable
//            wrap     - one-cycle pulse after a wrap or saturation edge
//            ovf      - sticky wrap/saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = MODE_WRAP,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // ------------------------------------------------------------------------
    // Parameter legality. WIDTH is capped at 31 so that MAX_COUNT fits an int
    // and leaves headroom inside the shared step function.
    // ------------------------------------------------------------------------
    if (WIDTH < 2 || WIDTH > 31) begin : g_chk_width
        $error("param_updown_counter: WIDTH must be in 2..31");
    end
    if (MAX_COUNT < 0 || 64'(MAX_COUNT) > ((64'(1) << WIDTH) - 64'(1))) begin : g_chk_max
        $error("param_updown_counter: MAX_COUNT exceeds 2**WIDTH-1");
    end
    if (RESET_VAL < 0 || RESET_VAL > MAX_COUNT) begin : g_chk_rst
        $error("param_updown_counter: RESET_VAL exceeds MAX_COUNT");
    end

    localparam logic [WIDTH-1:0]  c_MAX   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0]  c_RST   = WIDTH'(RESET_VAL);
    localparam logic [c_FN_W-1:0] c_MAX32 = c_FN_W'(MAX_COUNT);
    localparam logic              c_SAT   = (SATURATE != MODE_WRAP);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic [c_FN_W:0]  w_nxt;
    logic [WIDTH-1:0] w_next_q;
    logic             w_event;
    logic [WIDTH-1:0] w_load_q;
    logic             w_hi_unused;

    assign w_nxt    = next_count(c_FN_W'(r_q), up_dn, c_MAX32, c_SAT);
    assign w_next_q = w_nxt[WIDTH-1:0];
    assign w_event  = w_nxt[c_FN_W];

    // Upper bits of the step result are always zero for an in-range count.
    assign w_hi_unused = ^w_nxt[c_FN_W-1:WIDTH];

    // Out-of-range load values are clamped rather than truncated.
    assign w_load_q = (load_val > c_MAX) ? c_MAX : load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= c_RST;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_q;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_q    <= w_next_q;
            r_wrap <= w_event;
            if (w_event) begin
                r_ovf <= 1'b1;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

    // Asserts on the count that would cause an event if enabled, so the next
    // stage of a cascade advances exactly when this stage rolls over.
    assign tc = en & ((up_dn & (r_q == c_MAX)) | (~up_dn & (r_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updown_counter
// Purpose  : Directed self-checking bench for param_updown_counter. Covers
//            asynchronous reset, modulo-16 and modulo-10 counting, saturate
//            mode, clr/load/en priority with clamping, direction changes,
//            enable gating and a two-stage cascade.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus for the three single-stage instances
    logic       en       = 1'b0;
    logic       up_dn    = 1'b1;
    logic       clr      = 1'b0;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;

    // Cascade stimulus
    logic       c_en  = 1'b0;
    logic       c_clr = 1'b0;

    logic [3:0] q4, qm, qs, q_lo, q_hi;
    logic       tc4, wrap4, ovf4;
    logic       tcm, wrapm, ovfm;
    logic       tcs, wraps, ovfs;
    logic       tc_lo, wrap_lo, ovf_lo, tc_hi, wrap_hi, ovf_hi;

    int n_vec = 0;
    int n_err = 0;

    // 4-bit, wrap
    param_updown_counter #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(q4), .tc(tc4), .wrap(wrap4), .ovf(ovf4));

    // modulo 10, wrap
    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9)) u_m10 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(qm), .tc(tcm), .wrap(wrapm), .ovf(ovfm));

    // 4-bit, saturate, non-zero reset value
    param_updown_counter #(.WIDTH(4), .SATURATE(1), .RESET_VAL(3)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(qs), .tc(tcs), .wrap(wraps), .ovf(ovfs));

    // Two-stage cascade: low stage tc enables the high stage
    param_updown_counter #(.WIDTH(4)) u_lo (
        .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .q(q_lo), .tc(tc_lo), .wrap(wrap_lo), .ovf(ovf_lo));

    param_updown_counter #(.WIDTH(4)) u_hi (
        .clk(clk), .rst(rst), .en(tc_lo), .up_dn(1'b1), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .q(q_hi), .tc(tc_hi), .wrap(wrap_hi), .ovf(ovf_hi));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_vec++; if (q4 !== 4'd0 || wrap4 !== 1'b0 || ovf4 !== 1'b0) begin
            n_err++; $display("FAIL reset_init q=%0d wrap=%b ovf=%b want 0 0 0", q4, wrap4, ovf4); end
        n_vec++; if (qs !== 4'd3) begin
            n_err++; $display("FAIL reset_val q=%0d want 3", qs); end
        rst = 1'b1; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_vec++; if (q4 !== 4'd7) begin
            n_err++; $display("FAIL mid_count q=%0d want 7", q4); end
        // Assert reset between clock edges: must take effect with no edge
        #2 rst = 1'b0;
        #1;
        n_vec++; if (q4 !== 4'd0 || ovf4 !== 1'b0) begin
            n_err++; $display("FAIL async_reset q=%0d ovf=%b want 0 0", q4, ovf4); end
        n_vec++; if (qs !== 4'd3) begin
            n_err++; $display("FAIL async_reset_val q=%0d want 3", qs); end
        #1 rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_vec++; if (q4 !== 4'((i + 1) % 16) || wrap4 !== (i == 15)) begin
                n_err++; $display("FAIL release_count[%0d] q=%0d wrap=%b want %0d %b",
                                  i, q4, wrap4, (i + 1) % 16, (i == 15)); end
        end
        n_vec++; if (ovf4 !== 1'b1) begin
            n_err++; $display("FAIL release_ovf ovf=%b want 1", ovf4); end
        // wrap and ovf are both high now; async reset must clear them at once
        #2 rst = 1'b0;
        #1;
        n_vec++; if (wrap4 !== 1'b0 || ovf4 !== 1'b0) begin
            n_err++; $display("FAIL async_flags wrap=%b ovf=%b want 0 0", wrap4, ovf4); end
        #1 rst = 1'b1;
        en = 1'b0;
    endtask

    task automatic test_modulo10();
        clr = 1'b1; tick(); clr = 1'b0;
        n_vec++; if (qm !== 4'd0 || ovfm !== 1'b0) begin
            n_err++; $display("FAIL m10_clr q=%0d ovf=%b want 0 0", qm, ovfm); end
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_vec++; if (tcm !== (i % 10 == 9)) begin
                n_err++; $display("FAIL m10_tc[%0d] tc=%b want %b", i, tcm, (i % 10 == 9)); end
            tick();
            n_vec++; if (qm !== 4'((i + 1) % 10) || wrapm !== (i == 9)) begin
                n_err++; $display("FAIL m10_up[%0d] q=%0d wrap=%b want %0d %b",
                                  i, qm, wrapm, (i + 1) % 10, (i == 9)); end
        end
        clr = 1'b1; tick(); clr = 1'b0;
        up_dn = 1'b0;
        #1;
        n_vec++; if (tcm !== 1'b1) begin
            n_err++; $display("FAIL m10_tc_down tc=%b want 1", tcm); end
        tick();
        n_vec++; if (qm !== 4'd9 || wrapm !== 1'b1 || ovfm !== 1'b1) begin
            n_err++; $display("FAIL m10_down q=%0d wrap=%b ovf=%b want 9 1 1", qm, wrapm, ovfm); end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        n_vec++; if (qs !== 4'd0 || ovfs !== 1'b0) begin
            n_err++; $display("FAIL sat_clr q=%0d ovf=%b want 0 0", qs, ovfs); end
        load = 1'b1; load_val = 4'd14; tick(); load = 1'b0;
        n_vec++; if (qs !== 4'd14 || wraps !== 1'b0) begin
            n_err++; $display("FAIL sat_load q=%0d wrap=%b want 14 0", qs, wraps); end
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (qs !== 4'd15 || wraps !== (i > 0) || ovfs !== (i > 0)) begin
                n_err++; $display("FAIL sat_up[%0d] q=%0d wrap=%b ovf=%b want 15 %b %b",
                                  i, qs, wraps, ovfs, (i > 0), (i > 0)); end
        end
        en = 1'b0; load = 1'b1; load_val = 4'd0; tick(); load = 1'b0;
        n_vec++; if (qs !== 4'd0 || wraps !== 1'b0 || ovfs !== 1'b1) begin
            n_err++; $display("FAIL sat_load0 q=%0d wrap=%b ovf=%b want 0 0 1", qs, wraps, ovfs); end
        en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++; if (tcs !== 1'b1) begin
                n_err++; $display("FAIL sat_tc[%0d] tc=%b want 1", i, tcs); end
            tick();
            n_vec++; if (qs !== 4'd0 || wraps !== 1'b1) begin
                n_err++; $display("FAIL sat_down[%0d] q=%0d wrap=%b want 0 1", i, qs, wraps); end
        end
        en = 1'b0; up_dn = 1'b1;
    endtask

    task automatic test_priority();
        en = 1'b0; load = 1'b1; load_val = 4'd9; tick(); load = 1'b0;
        en = 1'b1; up_dn = 1'b1; tick();
        n_vec++; if (qm !== 4'd0 || wrapm !== 1'b1 || ovfm !== 1'b1) begin
            n_err++; $display("FAIL pri_wrap q=%0d wrap=%b ovf=%b want 0 1 1", qm, wrapm, ovfm); end
        load = 1'b1; load_val = 4'd5; tick();
        n_vec++; if (qm !== 4'd5 || wrapm !== 1'b0 || ovfm !== 1'b1) begin
            n_err++; $display("FAIL pri_load_en q=%0d wrap=%b ovf=%b want 5 0 1", qm, wrapm, ovfm); end
        clr = 1'b1; tick(); clr = 1'b0;
        n_vec++; if (qm !== 4'd0 || ovfm !== 1'b0 || wrapm !== 1'b0) begin
            n_err++; $display("FAIL pri_clr q=%0d ovf=%b wrap=%b want 0 0 0", qm, ovfm, wrapm); end
        tick();
        n_vec++; if (qm !== 4'd5) begin
            n_err++; $display("FAIL pri_load q=%0d want 5", qm); end
        load_val = 4'd12; tick();
        n_vec++; if (qm !== 4'd9) begin
            n_err++; $display("FAIL pri_clamp q=%0d want 9", qm); end
        n_vec++; if (q4 !== 4'd12) begin
            n_err++; $display("FAIL pri_noclamp q=%0d want 12", q4); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_direction();
        load = 1'b1; load_val = 4'd3; tick(); load = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dn = (i % 2 == 0);
            tick();
            n_vec++; if (q4 !== ((i % 2 == 0) ? 4'd4 : 4'd3) || wrap4 !== 1'b0) begin
                n_err++; $display("FAIL dir_flip[%0d] q=%0d wrap=%b want %0d 0",
                                  i, q4, wrap4, (i % 2 == 0) ? 4 : 3); end
        end
        en = 1'b0; load = 1'b1; load_val = 4'd15; tick(); load = 1'b0;
        en = 1'b1; up_dn = 1'b1; tick();
        n_vec++; if (q4 !== 4'd0 || wrap4 !== 1'b1) begin
            n_err++; $display("FAIL dir_wrap q=%0d wrap=%b want 0 1", q4, wrap4); end
        // Disabled at q=0 going down: tc would be 1 if en were ignored
        en = 1'b0; up_dn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (tc4 !== 1'b0) begin
                n_err++; $display("FAIL gate_tc[%0d] tc=%b want 0", i, tc4); end
            tick();
            n_vec++; if (q4 !== 4'd0 || wrap4 !== 1'b0 || ovf4 !== 1'b1) begin
                n_err++; $display("FAIL gate_hold[%0d] q=%0d wrap=%b ovf=%b want 0 0 1",
                                  i, q4, wrap4, ovf4); end
        end
        up_dn = 1'b1;
    endtask

    task automatic test_cascade();
        int hw = 0;
        int lw = 0;
        c_en = 1'b0; c_clr = 1'b1; tick(); c_clr = 1'b0;
        n_vec++; if ({q_hi, q_lo} !== 8'h00) begin
            n_err++; $display("FAIL casc_clr q=%h want 00", {q_hi, q_lo}); end
        c_en = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (wrap_hi) hw++;
            if (wrap_lo) lw++;
            if (i == 100) begin
                n_vec++; if ({q_hi, q_lo} !== 8'h64) begin
                    n_err++; $display("FAIL casc_100 q=%h want 64", {q_hi, q_lo}); end
            end
        end
        c_en = 1'b0;
        n_vec++; if ({q_hi, q_lo} !== 8'h00 || ovf_hi !== 1'b1) begin
            n_err++; $display("FAIL casc_256 q=%h ovf_hi=%b want 00 1", {q_hi, q_lo}, ovf_hi); end
        n_vec++; if (hw !== 1 || lw !== 16) begin
            n_err++; $display("FAIL casc_pulses hi=%0d lo=%0d want 1 16", hw, lw); end
    endtask

    initial begin
        test_reset();
        test_modulo10();
        test_saturate();
        test_priority();
        test_direction();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised synchronous successor to the team's 4-bit up counter.
- Counts up or down modulo MAX_COUNT+1, with enable, synchronous clear, parallel load, and selectable wrap or saturate mode.
- Terminal-count and event outputs let counters cascade and drive timers and sequencers elsewhere in the design.
- All flops are clocked by the single clk; no ripple clocking.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- MAX_COUNT, 2**WIDTH-1, highest count value; the count range is 0..MAX_COUNT.
- SATURATE, 0, 0 = wrap at the bounds; 1 = hold at the bounds.
- RESET_VAL, 0, value of q after reset; must be <= MAX_COUNT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  count enable for this cycle.
- up_dn  in  1  direction: 1 = up, 0 = down.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count (registered).
- tc  out  1  combinational terminal count: en & ((up_dn & q==MAX_COUNT) | (!up_dn & q==0)).
- wrap  out  1  registered one-cycle pulse; the previous edge wrapped or hit saturation.
- ovf  out  1  sticky flag; set by any wrap or saturation event, cleared by clr or reset.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-count):
  - q=RESET_VAL, wrap=0, ovf=0 immediately, without waiting for a clock edge.
  - Release is synchronous to the next clk edge; the first count occurs on the first edge with rst=1 and en=1.
- Per-edge priority: clr > load > en > hold.
- clr=1:
  - q<=0, ovf<=0, wrap<=0.
  - load and en are ignored.
- load=1 (clr=0):
  - q<=min(load_val, MAX_COUNT); out-of-range values are clamped.
  - wrap<=0; ovf unchanged; en is ignored.
- en=1, up_dn=1:
  - q<MAX_COUNT: q<=q+1.
  - q==MAX_COUNT, SATURATE=0: q<=0, wrap<=1, ovf<=1.
  - q==MAX_COUNT, SATURATE=1: q holds, wrap<=1, ovf<=1.
- en=1, up_dn=0:
  - q>0: q<=q-1.
  - q==0, SATURATE=0: q<=MAX_COUNT, wrap<=1, ovf<=1.
  - q==0, SATURATE=1: q holds at 0, wrap<=1, ovf<=1.
- en=0: q, ovf hold; wrap<=0.
- wrap is high for exactly one cycle per event. Back-to-back events (e.g. MAX_COUNT=0, or saturated with en held) keep wrap high on each such edge.
- Arithmetic:
  - Compute next value in WIDTH+1 bits; compare against MAX_COUNT, never rely on natural overflow.
  - Non-power-of-2 MAX_COUNT must wrap correctly.
- Direction may change on any cycle; it takes effect on that edge with no latency penalty.
- Latency: q updates one clk edge after the qualifying inputs; tc reflects the current q/en combinationally.
- Cascading: the next stage's en = this stage's tc.
- Elaboration errors:
  - MAX_COUNT > 2**WIDTH-1
  - RESET_VAL > MAX_COUNT
  - WIDTH < 2

Decomposition:
- Package counter_pkg:
  - mode localparams MODE_WRAP=0 and MODE_SAT=1.
  - a function next_count(q, up_dn, max, sat) returning {event, next_q}, so the future multi-channel counter can reuse it.
- Single module, no sub-modules. A cascade wrapper (param_counter_chain) is out of scope.

Test Plan:
- Reset and release: rst=0 mid-count at q=7 -> q=0, ovf=0 immediately with no clk edge. Release, en=1 up, 16 edges (WIDTH=4) -> q goes 1..15,0; wrap pulses once on the 15->0 edge; ovf=1.
- Modulo 10 (MAX_COUNT=9): up 12 edges -> q=0..9,0,1; tc=1 only while q=9. Down from 0 -> q=9, wrap=1.
- Saturate mode (SATURATE=1, WIDTH=4):
  - Load 14, up 3 edges -> q=15,15,15; wrap=0,1,1; ovf=1.
  - Then down from 0 with q held at 0 -> q stays 0, wrap=1.
- Priority: clr=1, load=1 (load_val=5), en=1 on the same edge -> q=0, ovf=0. Next edge load=1, en=1 -> q=5. Then load_val=12 with MAX_COUNT=9 -> q=9 (clamped).
- Direction flip and enable gating:
  - q=3, alternate up_dn each edge with en=1 -> q=4,3,4,3.
  - en=0 for 5 edges -> q holds, wrap=0, tc=0.
- Cascade: two WIDTH=4 instances, the low stage's tc driving the high stage's en; 256 up edges from 0 -> {hi,lo} reads 0x00 again; the high stage's wrap pulses once.
